// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Holds the program counter, issues single-word
// memory reads at the PC on request, and latches the returned word into the
// instruction register. A four-state controller (IDLE, REQ, WAIT, DONE)
// sequences each fetch. A read that sees no mem_ready for TIMEOUT wait cycles
// is abandoned. Misaligned fetch attempts and timeouts raise sticky flags.
//
// Parameters
//   RESET_PC   PC value loaded by reset
//   TIMEOUT    wait cycles without mem_ready before a fetch is abandoned (1..255)
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   pc_en       in   PC update request (accepted in IDLE only)
//   pc_in_dir   in   0: PC+4, 1: load target
//   pc_sign     in   with pc_in_dir=1: 0 absolute, 1 PC-relative signed
//   pc_in       in   [31:0] target address or two's-complement offset
//   ir_en       in   fetch request (accepted in IDLE only)
//   err_clr     in   clears misalign and bus_err
//   mem_rd      out  memory read strobe
//   mem_addr    out  [31:0] memory read address
//   mem_rdata   in   [31:0] memory read data
//   mem_ready   in   memory completion, looked at only while mem_rd=1
//   instr       out  [31:0] instruction register
//   pc          out  [31:0] current PC
//   fetch_busy  out  high while a read is outstanding
//   fetch_done  out  one-cycle pulse after the instruction register updates
//   misalign    out  sticky misaligned-fetch flag
//   bus_err     out  sticky fetch-timeout flag
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        pc_in_dir,
    input  logic        pc_sign,
    input  logic [31:0] pc_in,
    input  logic        ir_en,
    input  logic        err_clr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        misalign,
    output logic        bus_err
);

    // Controller states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Wait counter limit; TIMEOUT never exceeds 255 so 8 bits suffice
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] addr_q,     addr_d;
    logic [7:0]  waitCnt_q,  waitCnt_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        misalign_q, misalign_d;
    logic        busErr_q,   busErr_d;

    logic [31:0] pcNext;

    // Candidate next PC for an accepted pc_en. Addition wraps modulo 2^32,
    // which also covers negative relative offsets in two's complement.
    always_comb begin
        pcNext = pc_q + 32'd4;
        if (pc_in_dir) begin
            if (pc_sign) begin
                pcNext = pc_q + pc_in;
            end else begin
                pcNext = pc_in;
            end
        end
    end

    // Next-state logic for the controller and all datapath registers.
    // Error flags: the clear is applied first so that a set in the same
    // cycle overrides it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        waitCnt_d  = waitCnt_q;
        misalign_d = misalign_q;
        busErr_d   = busErr_q;

        if (err_clr) begin
            misalign_d = 1'b0;
            busErr_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // A fetch in the same cycle uses the old PC (pc_q), while
                // the PC itself advances on the same edge.
                if (pc_en) begin
                    pc_d = pcNext;
                end
                if (ir_en) begin
                    if (pc_q[1:0] == 2'b00) begin
                        addr_d  = pc_q;
                        state_d = S_REQ;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end

            S_REQ: begin
                if (mem_ready) begin
                    instr_d   = mem_rdata;
                    waitCnt_d = 8'd0;
                    state_d   = S_DONE;
                end else begin
                    waitCnt_d = 8'd1;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                // Data arriving in the final permitted wait cycle still
                // completes the fetch; only a missing ready then aborts it.
                if (mem_ready) begin
                    instr_d   = mem_rdata;
                    waitCnt_d = 8'd0;
                    state_d   = S_DONE;
                end else if (waitCnt_q == TIMEOUT_CNT) begin
                    busErr_d  = 1'b1;
                    waitCnt_d = 8'd0;
                    state_d   = S_IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered, so they are decoded from the state
        // being entered rather than the current one.
        busy_d = (state_d == S_REQ) || (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
    end

    // State registers. Reset clears everything at once, which also abandons
    // any fetch in flight without touching memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            addr_q     <= 32'd0;
            waitCnt_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            busErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            waitCnt_q  <= waitCnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            busErr_q   <= busErr_d;
        end
    end

    // The read strobe and the busy flag cover the same two states, so a
    // single flop drives both.
    assign mem_rd     = busy_q;
    assign fetch_busy = busy_q;
    assign mem_addr   = addr_q;
    assign instr      = instr_q;
    assign pc         = pc_q;
    assign fetch_done = done_q;
    assign misalign   = misalign_q;
    assign bus_err    = busErr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A transaction-level model tracks the
// PC, instruction register and sticky flags; fetch outcomes (busy length,
// completion or timeout) are predicted from the memory latency alone.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 16;

    logic        clk;
    logic        rst;
    logic        pc_en;
    logic        pc_in_dir;
    logic        pc_sign;
    logic [31:0] pc_in;
    logic        ir_en;
    logic        err_clr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fetch_busy;
    logic        fetch_done;
    logic        misalign;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] modelPc;
    logic [31:0] modelInstr;
    logic        modelMisalign;
    logic        modelBusErr;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_en      (pc_en),
        .pc_in_dir  (pc_in_dir),
        .pc_sign    (pc_sign),
        .pc_in      (pc_in),
        .ir_en      (ir_en),
        .err_clr    (err_clr),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .instr      (instr),
        .pc         (pc),
        .fetch_busy (fetch_busy),
        .fetch_done (fetch_done),
        .misalign   (misalign),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse asserted mid-cycle; released away from the rising edge
    task automatic pulse_reset_begin();
        #3;
        rst = 1'b1;
        #1;
        modelPc       = RST_PC;
        modelInstr    = 32'd0;
        modelMisalign = 1'b0;
        modelBusErr   = 1'b0;
    endtask

    task automatic pulse_reset_end();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // One PC update in IDLE; model applies the arithmetic rule directly
    task automatic pc_update(input logic dir, input logic sgn, input logic [31:0] val);
        pc_en     = 1'b1;
        pc_in_dir = dir;
        pc_sign   = sgn;
        pc_in     = val;
        tick();
        pc_en = 1'b0;
        if (!dir)     modelPc = modelPc + 32'd4;
        else if (!sgn) modelPc = val;
        else          modelPc = modelPc + val;
        checks++;
        if (pc !== modelPc) begin
            failures++;
            $display("[TB] FAIL pc_update dir=%0b sgn=%0b val=%h: got %h want %h", dir, sgn, val, pc, modelPc);
        end
    endtask

    // Request one fetch. The memory raises mem_ready after `lat` cycles of
    // outstanding read (lat > TO means it never answers in time).
    task automatic do_fetch(input int lat, input logic [31:0] data);
        logic [31:0] fetchAddr;
        logic        aligned;
        logic        expDone;
        int          k;
        int          expBusy;
        fetchAddr = modelPc;
        aligned   = (modelPc[1:0] == 2'b00);
        k         = 0;
        ir_en     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = data;
        tick();
        ir_en = 1'b0;
        while (fetch_busy === 1'b1 && k < 300) begin
            checks++;
            if ({mem_rd, mem_addr} !== {1'b1, fetchAddr}) begin
                failures++;
                $display("[TB] FAIL fetch_addr cycle %0d: got rd=%b addr=%h want rd=1 addr=%h", k, mem_rd, mem_addr, fetchAddr);
            end
            mem_ready = (k == lat);
            tick();
            k++;
        end
        mem_ready = 1'b0;

        expDone = 1'b0;
        if (!aligned) begin
            expBusy       = 0;
            modelMisalign = 1'b1;
        end else if (lat <= TO) begin
            expBusy    = lat + 1;
            modelInstr = data;
            expDone    = 1'b1;
        end else begin
            expBusy     = TO + 1;
            modelBusErr = 1'b1;
        end

        checks++;
        if (k !== expBusy) begin
            failures++;
            $display("[TB] FAIL busy_len lat=%0d: got %0d want %0d", lat, k, expBusy);
        end
        checks++;
        if ({fetch_done, mem_rd, fetch_busy} !== {expDone, 2'b00}) begin
            failures++;
            $display("[TB] FAIL fetch_end lat=%0d: got done=%b rd=%b busy=%b want done=%b rd=0 busy=0",
                     lat, fetch_done, mem_rd, fetch_busy, expDone);
        end
        checks++;
        if (instr !== modelInstr) begin
            failures++;
            $display("[TB] FAIL instr lat=%0d: got %h want %h", lat, instr, modelInstr);
        end
        checks++;
        if ({misalign, bus_err} !== {modelMisalign, modelBusErr}) begin
            failures++;
            $display("[TB] FAIL flags lat=%0d: got mis=%b berr=%b want mis=%b berr=%b",
                     lat, misalign, bus_err, modelMisalign, modelBusErr);
        end
        checks++;
        if (pc !== modelPc) begin
            failures++;
            $display("[TB] FAIL pc_after_fetch: got %h want %h", pc, modelPc);
        end
        if (expDone) begin
            tick();
            checks++;
            if (fetch_done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL done_pulse_width: got %b want 0", fetch_done);
            end
        end
    endtask

    task automatic err_clear();
        err_clr = 1'b1;
        tick();
        err_clr       = 1'b0;
        modelMisalign = 1'b0;
        modelBusErr   = 1'b0;
        checks++;
        if ({misalign, bus_err} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL err_clear: got mis=%b berr=%b want 0 0", misalign, bus_err);
        end
    endtask

    // Asynchronous reset values appear without waiting for a clock edge
    task automatic test_reset();
        pulse_reset_begin();
        checks++;
        if ({pc, instr, mem_addr, mem_rd, fetch_busy, fetch_done, misalign, bus_err} !==
            {RST_PC, 32'd0, 32'd0, 5'b00000}) begin
            failures++;
            $display("[TB] FAIL reset_values: got pc=%h ir=%h addr=%h rd=%b busy=%b done=%b mis=%b berr=%b",
                     pc, instr, mem_addr, mem_rd, fetch_busy, fetch_done, misalign, bus_err);
        end
        pulse_reset_end();
    endtask

    task automatic test_zero_wait();
        do_fetch(0, 32'h0041_0093);
    endtask

    task automatic test_wait_states();
        do_fetch(3, 32'hCAFE_0013);
        do_fetch(TO, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            do_fetch($urandom_range(0, TO), $urandom);
        end
    endtask

    task automatic test_timeout();
        do_fetch(1000, 32'hBAD0_BAD0);
        err_clear();
    endtask

    task automatic test_pc_arith();
        pc_update(1'b1, 1'b0, 32'h0000_0100);
        pc_update(1'b1, 1'b1, 32'hFFFF_FFF0);
        pc_update(1'b1, 1'b0, 32'h0000_2000);
        pc_update(1'b1, 1'b0, 32'hFFFF_FFFC);
        pc_update(1'b0, 1'b0, 32'h1111_1111);
    endtask

    task automatic test_misalign();
        logic [31:0] irBefore;
        pc_update(1'b1, 1'b0, 32'h0000_0102);
        irBefore = modelInstr;
        do_fetch(0, 32'h5555_5555);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({mem_rd, fetch_done, instr} !== {2'b00, irBefore}) begin
                failures++;
                $display("[TB] FAIL misalign_quiet: got rd=%b done=%b ir=%h want 0 0 %h", mem_rd, fetch_done, instr, irBefore);
            end
        end
        // A new misaligned attempt while clearing: the set wins
        err_clr = 1'b1;
        ir_en   = 1'b1;
        tick();
        err_clr = 1'b0;
        ir_en   = 1'b0;
        checks++;
        if (misalign !== 1'b1) begin
            failures++;
            $display("[TB] FAIL set_over_clear: got %b want 1", misalign);
        end
        err_clear();
    endtask

    task automatic test_simultaneous();
        pc_update(1'b1, 1'b0, 32'h0000_0040);
        pc_en     = 1'b1;
        pc_in_dir = 1'b0;
        ir_en     = 1'b1;
        mem_ready = 1'b0;
        tick();
        pc_en   = 1'b0;
        ir_en   = 1'b0;
        modelPc = 32'h0000_0044;
        checks++;
        if ({mem_rd, mem_addr, pc} !== {1'b1, 32'h0000_0040, 32'h0000_0044}) begin
            failures++;
            $display("[TB] FAIL pc_and_ir: got rd=%b addr=%h pc=%h want 1 00000040 00000044", mem_rd, mem_addr, pc);
        end
        tick();
        // Now waiting on memory: PC updates and fetch requests are ignored
        pc_en     = 1'b1;
        pc_in_dir = 1'b1;
        pc_sign   = 1'b0;
        pc_in     = 32'hDEAD_0000;
        ir_en     = 1'b1;
        tick();
        pc_en = 1'b0;
        ir_en = 1'b0;
        checks++;
        if ({fetch_busy, pc, mem_addr} !== {1'b1, 32'h0000_0044, 32'h0000_0040}) begin
            failures++;
            $display("[TB] FAIL pc_en_in_wait: got busy=%b pc=%h addr=%h want 1 00000044 00000040", fetch_busy, pc, mem_addr);
        end
        // Reset in the middle of the wait abandons the fetch at once
        pulse_reset_begin();
        checks++;
        if ({mem_rd, fetch_busy, instr, pc} !== {2'b00, 32'd0, RST_PC}) begin
            failures++;
            $display("[TB] FAIL rst_in_wait: got rd=%b busy=%b ir=%h pc=%h", mem_rd, fetch_busy, instr, pc);
        end
        pulse_reset_end();
        do_fetch(1, 32'h0ACE_0ACE);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: pc_update(1'b0, 1'b0, $urandom);
                1: pc_update(1'b1, 1'b0, ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
                2: pc_update(1'b1, 1'b1, 32'($signed($urandom_range(0, 64)) - 32) << 2);
                3: err_clear();
                default: do_fetch($urandom_range(0, TO + 2), $urandom);
            endcase
        end
    endtask

    initial begin
        rst       = 1'b1;
        pc_en     = 1'b0;
        pc_in_dir = 1'b0;
        pc_sign   = 1'b0;
        pc_in     = 32'd0;
        ir_en     = 1'b0;
        err_clr   = 1'b0;
        mem_rdata = 32'd0;
        mem_ready = 1'b0;
        modelPc       = RST_PC;
        modelInstr    = 32'd0;
        modelMisalign = 1'b0;
        modelBusErr   = 1'b0;
        repeat (2) @(posedge clk);
        pulse_reset_end();

        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_pc_arith();
        test_misalign();
        test_simultaneous();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
